// File: rtl/array_mac_seq.sv
// Command sequencer for the in-memory compute array: streams MAC bit-planes
// or a single SEARCH column select, then gathers the adder-tree sums through a
// fixed-latency tag pipeline and returns the result on a valid/ready port.
module array_mac_seq #(
  parameter int unsigned ROWS     = 16,
  parameter int unsigned ABITS    = 8,
  parameter int unsigned COLS     = 8,
  parameter int unsigned TREE_LAT = 2,
  parameter int unsigned SUM_W    = 12,
  parameter int unsigned ACC_W    = 20
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_op,
  input  logic [ROWS*ABITS-1:0]   cmd_act,
  input  logic [COLS-1:0]         cmd_col_mask,
  output logic                    mac_en,
  output logic [COLS-1:0]         col_mux,
  output logic [ROWS-1:0]         data_in,
  input  logic [SUM_W-1:0]        tree_sum,
  output logic                    res_valid,
  input  logic                    res_ready,
  output logic [ACC_W-1:0]        res_data,
  output logic                    busy
);

  localparam int unsigned PW = (ABITS > 1) ? $clog2(ABITS) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]            state, state_d;
  logic                  op_q, op_d;
  logic [ROWS*ABITS-1:0] act_q, act_d;
  logic [PW-1:0]         plane_q, plane_d;   // planes still to be driven
  logic [ACC_W-1:0]      acc_q, acc_d, acc_nxt;

  logic [TREE_LAT-1:0]   tag_v, tag_op, tag_last;
  logic                  push, push_op, push_last;
  logic                  emerge, emerge_last;

  logic                  mac_en_d, res_valid_d, cmd_ready_d, busy_d;
  logic [COLS-1:0]       col_mux_d;
  logic [ROWS-1:0]       data_in_d;
  logic [ACC_W-1:0]      res_data_d;

  // Gather bit idx of every row's activation into one plane.
  function automatic logic [ROWS-1:0] plane_of(input logic [ROWS*ABITS-1:0] a,
                                               input int unsigned idx);
    logic [ROWS-1:0] p;
    p = '0;
    for (int unsigned r = 0; r < ROWS; r++) p[r] = a[r*ABITS + idx];
    return p;
  endfunction

  assign emerge      = tag_v[TREE_LAT-1];
  assign emerge_last = emerge & tag_last[TREE_LAT-1];

  // Accumulator update for the tag leaving the pipeline this cycle.
  always_comb begin
    acc_nxt = acc_q;
    if (emerge) begin
      if (tag_op[TREE_LAT-1]) acc_nxt = ACC_W'(tree_sum);
      else                    acc_nxt = (acc_q << 1) + ACC_W'(tree_sum);
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d     = state;
    op_d        = op_q;
    act_d       = act_q;
    plane_d     = plane_q;
    acc_d       = acc_q;
    mac_en_d    = 1'b0;
    col_mux_d   = '0;
    data_in_d   = '0;
    res_valid_d = res_valid;
    res_data_d  = res_data;
    push        = 1'b0;
    push_op     = 1'b0;
    push_last   = 1'b0;

    case (state)
      S_IDLE: begin
        if (cmd_valid && cmd_ready) begin
          op_d    = cmd_op;
          act_d   = cmd_act;
          acc_d   = '0;
          state_d = S_ISSUE;
          push    = 1'b1;
          push_op = cmd_op;
          if (!cmd_op) begin
            mac_en_d  = 1'b1;
            data_in_d = plane_of(cmd_act, ABITS - 1);
            plane_d   = PW'(ABITS - 1);
            push_last = (ABITS == 1);
          end else begin
            col_mux_d = cmd_col_mask;
            plane_d   = '0;
            push_last = 1'b1;
          end
        end
      end

      S_ISSUE: begin
        acc_d = acc_nxt;
        if (!op_q && (plane_q != '0)) begin
          mac_en_d  = 1'b1;
          data_in_d = plane_of(act_q, 32'(plane_q) - 32'd1);
          plane_d   = PW'(plane_q - PW'(1));
          push      = 1'b1;
          push_last = (plane_q == PW'(1));
          if (plane_q == PW'(1)) state_d = S_DRAIN;
        end else begin
          state_d = S_DRAIN;
        end
        if (emerge_last) begin
          state_d     = S_DONE;
          res_valid_d = 1'b1;
          res_data_d  = acc_nxt;
        end
      end

      S_DRAIN: begin
        acc_d = acc_nxt;
        if (emerge_last) begin
          state_d     = S_DONE;
          res_valid_d = 1'b1;
          res_data_d  = acc_nxt;
        end
      end

      default: begin
        if (res_ready) begin
          res_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
    endcase

    cmd_ready_d = (state_d == S_IDLE);
    busy_d      = (state_d != S_IDLE);
  end

  // State, datapath and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      op_q      <= 1'b0;
      act_q     <= '0;
      plane_q   <= '0;
      acc_q     <= '0;
      tag_v     <= '0;
      tag_op    <= '0;
      tag_last  <= '0;
      mac_en    <= 1'b0;
      col_mux   <= '0;
      data_in   <= '0;
      res_valid <= 1'b0;
      res_data  <= '0;
      cmd_ready <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_d;
      op_q      <= op_d;
      act_q     <= act_d;
      plane_q   <= plane_d;
      acc_q     <= acc_d;
      for (int unsigned i = TREE_LAT - 1; i > 0; i--) begin
        tag_v[i]    <= tag_v[i-1];
        tag_op[i]   <= tag_op[i-1];
        tag_last[i] <= tag_last[i-1];
      end
      tag_v[0]    <= push;
      tag_op[0]   <= push_op;
      tag_last[0] <= push_last;
      mac_en    <= mac_en_d;
      col_mux   <= col_mux_d;
      data_in   <= data_in_d;
      res_valid <= res_valid_d;
      res_data  <= res_data_d;
      cmd_ready <= cmd_ready_d;
      busy      <= busy_d;
    end
  end

endmodule

// File: tb/tb_array_mac_seq.sv
// Bench for array_mac_seq: behavioural array/adder-tree model, directed
// commands with hand-computed results queued into a scoreboard, and a
// monitor that pops and compares on every result handshake.
module tb_array_mac_seq;

  localparam int unsigned ROWS  = 16;
  localparam int unsigned ABITS = 8;
  localparam int unsigned COLS  = 8;
  localparam int unsigned SUM_W = 12;
  localparam int unsigned ACC_W = 20;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic                  cmd_valid = 1'b0;
  logic                  cmd_ready;
  logic                  cmd_op = 1'b0;
  logic [ROWS*ABITS-1:0] cmd_act = '0;
  logic [COLS-1:0]       cmd_col_mask = '0;
  logic                  mac_en;
  logic [COLS-1:0]       col_mux;
  logic [ROWS-1:0]       data_in;
  logic [SUM_W-1:0]      tree_sum = '0;
  logic                  res_valid;
  logic                  res_ready = 1'b1;
  logic [ACC_W-1:0]      res_data;
  logic                  busy;

  array_mac_seq #(.ROWS(ROWS), .ABITS(ABITS), .COLS(COLS), .TREE_LAT(2),
                  .SUM_W(SUM_W), .ACC_W(ACC_W)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_act(cmd_act), .cmd_col_mask(cmd_col_mask),
    .mac_en(mac_en), .col_mux(col_mux), .data_in(data_in),
    .tree_sum(tree_sum), .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int last_rise = 0;
  int n_rise = 0;
  int ovl = 0;
  logic rv_prev = 1'b0;
  logic [ACC_W-1:0] exp_q[$];
  logic [7:0] w [ROWS];
  logic [SUM_W-1:0] s_prev = '0;

  always @(posedge clk) cyc <= cyc + 1;

  // Array plus adder tree: sum of selected weights (MAC) or of masked weight bits (SEARCH).
  function automatic logic [SUM_W-1:0] arr_sum();
    int s;
    s = 0;
    for (int r = 0; r < ROWS; r++) begin
      if (mac_en) s += data_in[r] ? int'(w[r]) : 0;
      else        s += $countones(w[r] & col_mux);
    end
    return SUM_W'(s);
  endfunction

  // Two-edge tree latency: controls from edge E are summed and presented for edge E+2.
  always @(negedge clk) begin
    tree_sum = s_prev;
    s_prev   = arr_sum();
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", name, got, want);
    end
  endtask

  // Result monitor and control-overlap watch.
  always @(negedge clk) begin
    if (!rst) begin
      if (res_valid && !rv_prev) begin
        last_rise = cyc;
        n_rise++;
      end
      if ((mac_en && col_mux != '0) || (!mac_en && data_in != '0)) ovl++;
      if (res_valid && res_ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_result: got %0h want none", res_data);
        end else begin
          chk("res_data", 32'(res_data), 32'(exp_q.pop_front()));
        end
      end
    end
    rv_prev = res_valid;
  end

  function automatic logic [ROWS*ABITS-1:0] act_all(input logic [7:0] v);
    return {ROWS{v}};
  endfunction

  task automatic set_w(input logic [7:0] v);
    for (int r = 0; r < ROWS; r++) w[r] = v;
  endtask

  task automatic issue(input logic op, input logic [ROWS*ABITS-1:0] act,
                       input logic [7:0] mask, input logic do_push,
                       input logic [ACC_W-1:0] want, output int e0);
    int n;
    n = 0;
    @(posedge clk); #1;
    cmd_op = op; cmd_act = act; cmd_col_mask = mask; cmd_valid = 1'b1;
    if (do_push) exp_q.push_back(want);
    @(negedge clk);
    while (!cmd_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) chk("accept_timeout", 32'(cmd_ready), 32'd1);
    @(posedge clk); #1;
    e0 = cyc;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    @(negedge clk);
    while ((exp_q.size() != 0 || busy) && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk(name, 32'(n >= 400), 32'd0);
  endtask

  initial begin
    int e0, rel, k_bad, nr;
    logic [ROWS*ABITS-1:0] ramp;
    logic md [10];
    logic [ROWS-1:0] dd [10];
    logic [COLS-1:0] cm [2];
    logic sm [2];

    set_w(8'h00);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_mac_en", 32'(mac_en), 0);
    chk("rst_col_mux", 32'(col_mux), 0);
    chk("rst_data_in", 32'(data_in), 0);
    chk("rst_res_valid", 32'(res_valid), 0);
    chk("rst_res_data", 32'(res_data), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_cmd_ready", 32'(cmd_ready), 0);
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk); #1;
    chk("cmd_ready_after_rst", 32'(cmd_ready), 1);

    // MAC timing: weights 3, activations 1 -> 16*3 = 48 on plane 0 only.
    set_w(8'h03);
    issue(1'b0, act_all(8'h01), 8'h00, 1'b1, 20'd48, e0);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      md[k] = mac_en;
      dd[k] = data_in;
    end
    nr = 0;
    for (int k = 0; k < 10; k++) nr += md[k] ? 1 : 0;
    chk("mac_en_cycles", 32'(nr), 8);
    chk("mac_en_off_after", 32'(md[8]), 0);
    for (int k = 0; k < 8; k++)
      chk("plane_data_in", 32'(dd[k]), (k == 7) ? 32'h0000FFFF : 32'h0);
    chk("data_in_drain", 32'(dd[8]), 0);
    wait_done("mac1_timeout");
    chk("mac_latency", 32'(last_rise - e0), 9);

    // MAC full scale: 16 * 255 * 255.
    set_w(8'hFF);
    issue(1'b0, act_all(8'hFF), 8'h00, 1'b1, 20'hFE010, e0);
    wait_done("mac_full_timeout");
    chk("mac_full_latency", 32'(last_rise - e0), 9);

    // All-zero activations still run every plane.
    issue(1'b0, act_all(8'h00), 8'h00, 1'b1, 20'd0, e0);
    for (int k = 0; k < 9; k++) begin
      @(negedge clk);
      md[k] = mac_en;
    end
    nr = 0;
    for (int k = 0; k < 9; k++) nr += md[k] ? 1 : 0;
    chk("zero_act_planes", 32'(nr), 8);
    wait_done("mac_zero_timeout");
    chk("mac_zero_latency", 32'(last_rise - e0), 9);

    // SEARCH: bank0 = 81, bank5 = 01, mask 01 -> 2 hits.
    set_w(8'h00); w[0] = 8'h81; w[5] = 8'h01;
    issue(1'b1, '0, 8'h01, 1'b1, 20'd2, e0);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      cm[k] = col_mux;
      sm[k] = mac_en;
    end
    chk("search_col_mux", 32'(cm[0]), 32'h01);
    chk("search_mac_en", 32'(sm[0]), 0);
    chk("search_col_mux_off", 32'(cm[1]), 0);
    wait_done("search_timeout");
    chk("search_latency", 32'(last_rise - e0), 2);

    // SEARCH with an empty mask yields zero.
    issue(1'b1, '0, 8'h00, 1'b1, 20'd0, e0);
    wait_done("search_zero_timeout");

    // Back-pressure: result held while res_ready low, stray cmd_valid ignored.
    res_ready = 1'b0;
    issue(1'b1, '0, 8'h01, 1'b1, 20'd2, e0);
    cmd_valid = 1'b1;
    nr = 0;
    @(negedge clk);
    while (!res_valid && nr < 50) begin
      @(negedge clk);
      nr++;
    end
    chk("bp_res_valid", 32'(res_valid), 1);
    k_bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!res_valid || res_data !== 20'd2 || cmd_ready || !busy) k_bad++;
    end
    chk("bp_hold_stable", 32'(k_bad), 0);
    exp_q.push_back(20'd2);
    @(posedge clk); #1 res_ready = 1'b1;
    @(posedge clk); #1;
    rel = cyc;
    chk("bp_release_idle", 32'(busy), 0);
    chk("bp_release_ready", 32'(cmd_ready), 1);
    chk("bp_release_valid", 32'(res_valid), 0);
    @(posedge clk); #1;
    chk("bp_next_accepted", 32'(busy), 1);
    chk("bp_next_ready_low", 32'(cmd_ready), 0);
    cmd_valid = 1'b0;
    wait_done("bp_timeout");
    chk("bp_next_latency", 32'(last_rise - rel), 3);

    // Reset mid-MAC: abandon silently, then a fresh SEARCH works.
    set_w(8'h03);
    issue(1'b0, act_all(8'h01), 8'h00, 1'b0, 20'd0, e0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    nr = n_rise;
    @(posedge clk); #1;
    chk("midrst_mac_en", 32'(mac_en), 0);
    chk("midrst_data_in", 32'(data_in), 0);
    chk("midrst_col_mux", 32'(col_mux), 0);
    chk("midrst_res_valid", 32'(res_valid), 0);
    chk("midrst_res_data", 32'(res_data), 0);
    chk("midrst_busy", 32'(busy), 0);
    rst = 1'b0;
    repeat (15) @(posedge clk);
    #1 chk("midrst_no_result", 32'(n_rise - nr), 0);
    set_w(8'h00); w[0] = 8'h81; w[5] = 8'h01;
    issue(1'b1, '0, 8'h01, 1'b1, 20'd2, e0);
    wait_done("midrst_search_timeout");

    // Back-to-back MAC then SEARCH: ramp acts 0..15 with weight 3 -> 360; mask 03 -> 32.
    set_w(8'h03);
    for (int r = 0; r < ROWS; r++) ramp[r*ABITS +: ABITS] = 8'(r);
    issue(1'b0, ramp, 8'h00, 1'b1, 20'd360, e0);
    issue(1'b1, '0, 8'h03, 1'b1, 20'd32, e0);
    wait_done("b2b_timeout");

    chk("control_overlap", 32'(ovl), 0);
    chk("queue_empty", 32'(exp_q.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/array_mac_seq.md
Name: array_mac_seq

Overview:
- Command-driven sequencer for the in-memory compute array (array logic plus its downstream adder tree).
- Accepts one MAC or SEARCH command at a time and drives the array's mac_en / col_mux / data_in controls.
- MAC: streams activation bit-planes MSB-first, one plane per cycle.
- Collects the adder-tree sum per plane with a fixed-latency tag pipeline, shift-accumulates it, and returns the result on a valid/ready port.

Parameters:
- ROWS, 16: number of banks/rows; width of data_in.
- ABITS, 8: activation precision; number of bit-planes per MAC.
- COLS, 8: array columns; width of col_mux.
- TREE_LAT, 2: cycles from a control edge to the edge where the matching tree_sum is sampled; legal range >= 1.
- SUM_W, 12: adder-tree sum width.
- ACC_W, 20: accumulator/result width; must be >= SUM_W+ABITS.

Ports:
- clk  in  1  rising-edge clock (the array's inverted clock is derived elsewhere).
- rst  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  high only in IDLE.
- cmd_op  in  1  0 = MAC, 1 = SEARCH.
- cmd_act  in  ROWS*ABITS  activations; row r occupies bits [r*ABITS +: ABITS].
- cmd_col_mask  in  COLS  column mask for SEARCH; ignored for MAC.
- mac_en  out  1  to array.
- col_mux  out  COLS  to array.
- data_in  out  ROWS  to array; bit r = current activation bit of row r.
- tree_sum  in  SUM_W  adder-tree output, unsigned.
- res_valid  out  1  result available.
- res_ready  in  1  result consumer ready.
- res_data  out  ACC_W  unsigned result.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (rst high at a clk edge) values:
  - state = IDLE.
  - mac_en = 0, col_mux = 0, data_in = 0.
  - res_valid = 0, res_data = 0, busy = 0.
  - tag pipeline cleared, accumulator = 0.
  - cmd_ready = 1 from the first edge after reset deasserts.
  - Reset mid-command abandons the command silently; no result is produced.
- All array controls and res_* are registered outputs.
- FSM states: IDLE, ISSUE, DRAIN, DONE.
- IDLE:
  - Command accepted on an edge E0 with cmd_valid & cmd_ready.
  - At E0: latch cmd_act and cmd_op, clear accumulator, set plane index p = ABITS-1, go to ISSUE.
- ISSUE, MAC:
  - Controls are updated at E0+k for k = 0..ABITS-1: mac_en = 1, col_mux = 0, data_in[r] = act[r][ABITS-1-k].
  - After the last plane is driven, go to DRAIN.
- ISSUE, SEARCH:
  - Controls are updated at E0 for one cycle only: mac_en = 0, col_mux = cmd_col_mask, data_in = 0.
  - Then go to DRAIN.
- Tag pipeline:
  - Depth TREE_LAT.
  - Each issued cycle pushes a tag; the tag emerges TREE_LAT edges later.
  - On an emerging MAC tag: acc <= (acc << 1) + tree_sum, zero-extended.
  - On an emerging SEARCH tag: acc <= tree_sum.
- DRAIN:
  - Controls return to 0 (mac_en = 0, col_mux = 0, data_in = 0) on the first DRAIN edge.
  - Wait until the tag pipeline is empty.
  - On the edge that consumes the last tag, load res_data with the final acc value, set res_valid = 1, go to DONE.
- Latency:
  - MAC: res_valid rises on edge E0+ABITS-1+TREE_LAT.
  - SEARCH: res_valid rises on edge E0+TREE_LAT.
- DONE:
  - res_valid and res_data are held stable until res_ready is high at an edge.
  - On that edge: res_valid = 0, go to IDLE.
  - No new command is accepted in the same edge; cmd_ready rises after it.
- Back-pressure: while res_ready stays low, the block stays in DONE indefinitely; cmd_ready = 0 throughout.
- cmd_valid high outside IDLE has no effect; commands are never queued.
- Arithmetic:
  - Unsigned; no saturation needed, since max 16*255*255 = 1,040,400 < 2^20.
  - Accumulator is never wider than ACC_W; tree_sum is zero-extended.
- Boundaries:
  - SEARCH with cmd_col_mask = 0 yields res_data = 0.
  - All-zero activations still run all ABITS planes.

Test Plan:
- MAC timing: after reset, all weights 8'h03, all acts 8'h01, TREE_LAT=2, MAC accepted at E0 -> res_data = 48, res_valid rises at E0+9; mac_en = 1 for exactly 8 cycles; data_in = 16'h0000 for planes 7..1 and 16'hFFFF for plane 0.
- MAC full scale: all weights 8'hFF, all acts 8'hFF -> res_data = 1,040,400 (20'hFE010), no truncation.
- SEARCH: bank0 = 8'h81, bank5 = 8'h01, others 0, cmd_col_mask = 8'h01 -> mac_en = 0, col_mux = 8'h01 for one cycle, res_data = 2, res_valid at E0+2.
- Back-pressure: hold res_ready = 0 for 20 cycles while cmd_valid = 1 -> res_valid/res_data stable, cmd_ready = 0, busy = 1; release -> IDLE next edge and the next command is accepted one edge later.
- Reset mid-MAC: assert rst at E0+4 -> all outputs 0 on that edge, no res_valid ever for the aborted command; a fresh SEARCH afterwards returns the correct count.
- Back-to-back: issue MAC then SEARCH with res_ready tied 1 -> two results in order, and no overlap of array controls between commands.
